// File: rtl/lsu_age_rs.sv
// lsu_age_rs: load/store reservation station with age-matrix ordering.
// Holds up to RS_DEPTH memory ops. Each op captures its operands from the CDB
// channels or the ROB commit port. The oldest ready op is issued through a
// registered valid/ready slot toward the AGU.
// Optional build macro LSU_RS_STORE_ORDER_EN: when it is defined, a load may
// not issue while an older store is still in the station or is waiting in the
// issue slot.
module lsu_age_rs #(
  parameter  int RS_DEPTH  = 8,
  parameter  int ROB_DEPTH = 16,
  parameter  int NUM_CDB   = 4,
  parameter  int XLEN      = 32,
  localparam int TAG_W     = $clog2(ROB_DEPTH),
  localparam int IDX_W     = $clog2(RS_DEPTH),
  localparam int OCC_W     = IDX_W + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  logic                            disp_is_store,
  input  logic [2:0]                      disp_funct3,
  input  logic [TAG_W-1:0]                disp_tag_dest,
  input  logic [TAG_W-1:0]                disp_tag_a,
  input  logic [XLEN-1:0]                 disp_data_a,
  input  logic                            disp_rdy_a,
  input  logic [TAG_W-1:0]                disp_tag_b,
  input  logic [XLEN-1:0]                 disp_data_b,
  input  logic                            disp_rdy_b,
  input  logic [XLEN-1:0]                 disp_imm,
  input  logic [NUM_CDB-1:0]              cdb_valid,
  input  logic [NUM_CDB-1:0][TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB-1:0][XLEN-1:0]    cdb_data,
  input  logic                            commit_valid,
  input  logic [TAG_W-1:0]                commit_tag,
  input  logic [XLEN-1:0]                 commit_data,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic                            issue_is_store,
  output logic [2:0]                      issue_funct3,
  output logic [TAG_W-1:0]                issue_tag,
  output logic [XLEN-1:0]                 issue_base,
  output logic [XLEN-1:0]                 issue_imm,
  output logic [XLEN-1:0]                 issue_store_data,
  output logic [OCC_W-1:0]                occupancy
);

  typedef struct packed {
    logic             is_store;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] tag_a;
    logic [TAG_W-1:0] tag_b;
    logic             rdy_a;
    logic             rdy_b;
    logic [XLEN-1:0]  data_a;
    logic [XLEN-1:0]  data_b;
    logic [XLEN-1:0]  imm;
  } entry_t;

  typedef struct packed {
    logic             is_store;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  base;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  store_data;
  } issue_t;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } snoop_t;

  // Search all result buses for a tag. The lowest CDB index wins, and the
  // commit port is used only when no CDB channel matches.
  function automatic snoop_t snoop(input logic [TAG_W-1:0] t);
    snoop_t r;
    r = '0;
    if (commit_valid && commit_tag == t) r = '{hit: 1'b1, data: commit_data};
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && cdb_tag[c] == t) r = '{hit: 1'b1, data: cdb_data[c]};
    end
    return r;
  endfunction

  entry_t [RS_DEPTH-1:0]               ent_q, ent_d;
  logic   [RS_DEPTH-1:0]               valid_q, valid_d;
  // older_q[i][j] = 1 means entry j is older than entry i.
  logic   [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;
  issue_t                              issue_q, issue_d;
  logic                                issue_valid_q, issue_valid_d;

  snoop_t [RS_DEPTH-1:0] snp_a, snp_b;
  snoop_t                disp_snp_a, disp_snp_b;
  logic   [RS_DEPTH-1:0] cand, sel;
  logic   [IDX_W-1:0]    alloc_idx, sel_idx;
  logic                  any_sel, disp_fire, slot_free, slot_take;
  entry_t                new_ent;

  // Operand snoop for each resident entry and for the op being dispatched.
  always_comb begin
    disp_snp_a = snoop(disp_tag_a);
    disp_snp_b = snoop(disp_tag_b);
    for (int i = 0; i < RS_DEPTH; i++) begin
      snp_a[i] = snoop(ent_q[i].tag_a);
      snp_b[i] = snoop(ent_q[i].tag_b);
    end
  end

  // Find the lowest-index free entry. A slot freed in this same cycle is not
  // available until the next cycle.
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign disp_ready = ~&valid_q;
  assign disp_fire  = disp_valid & disp_ready;

`ifdef LSU_RS_STORE_ORDER_EN
  logic [RS_DEPTH-1:0] is_store_vec;
  logic                store_in_slot;

  assign store_in_slot = issue_valid_q & issue_q.is_store & ~issue_ready;

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) is_store_vec[i] = ent_q[i].is_store;
  end
`endif

  // Age-ordered select: pick the ready entry that has no older ready entry.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      cand[i] = valid_q[i] & ent_q[i].rdy_a & (ent_q[i].rdy_b | ~ent_q[i].is_store);
`ifdef LSU_RS_STORE_ORDER_EN
      if (!ent_q[i].is_store &&
          ((|(older_q[i] & valid_q & is_store_vec)) || store_in_slot)) cand[i] = 1'b0;
`endif
    end
    for (int i = 0; i < RS_DEPTH; i++) sel[i] = cand[i] & ~|(older_q[i] & cand);
    any_sel = |cand;
    sel_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  assign slot_free = ~issue_valid_q | issue_ready;
  assign slot_take = slot_free & any_sel;

  // Build the incoming entry. An operand that is not yet ready may capture a
  // result broadcast in this same cycle. A load never waits on operand b.
  always_comb begin
    new_ent          = '0;
    new_ent.is_store = disp_is_store;
    new_ent.funct3   = disp_funct3;
    new_ent.tag      = disp_tag_dest;
    new_ent.tag_a    = disp_tag_a;
    new_ent.tag_b    = disp_tag_b;
    new_ent.imm      = disp_imm;
    new_ent.rdy_a    = disp_rdy_a | disp_snp_a.hit;
    new_ent.data_a   = (!disp_rdy_a && disp_snp_a.hit) ? disp_snp_a.data : disp_data_a;
    new_ent.rdy_b    = ~disp_is_store | disp_rdy_b | disp_snp_b.hit;
    new_ent.data_b   = (!disp_rdy_b && disp_snp_b.hit) ? disp_snp_b.data : disp_data_b;
  end

  // Next entry state: wakeup, free on issue, allocate on dispatch, flush.
  // NOTE: every variable assigned in always_comb receives a default value first, so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    older_d = older_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!ent_q[i].rdy_a && snp_a[i].hit) begin
        ent_d[i].rdy_a  = 1'b1;
        ent_d[i].data_a = snp_a[i].data;
      end
      if (!ent_q[i].rdy_b && snp_b[i].hit) begin
        ent_d[i].rdy_b  = 1'b1;
        ent_d[i].data_b = snp_b[i].data;
      end
    end
    if (slot_take) valid_d[sel_idx] = 1'b0;
    if (disp_fire) begin
      valid_d[alloc_idx] = 1'b1;
      ent_d[alloc_idx]   = new_ent;
      // The new entry is younger than every live entry. Clearing its column
      // removes stale age bits that other rows still hold for this index.
      older_d[alloc_idx] = valid_q;
      for (int i = 0; i < RS_DEPTH; i++) older_d[i][alloc_idx] = 1'b0;
    end
    if (flush) begin
      valid_d = '0;
      older_d = '0;
    end
  end

  // Issue slot: load when empty or draining, otherwise hold the payload.
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_d       = issue_q;
    if (slot_free) begin
      issue_valid_d = any_sel;
      if (any_sel) begin
        issue_d.is_store   = ent_q[sel_idx].is_store;
        issue_d.funct3     = ent_q[sel_idx].funct3;
        issue_d.tag        = ent_q[sel_idx].tag;
        issue_d.base       = ent_q[sel_idx].data_a;
        issue_d.imm        = ent_q[sel_idx].imm;
        issue_d.store_data = ent_q[sel_idx].data_b;
      end
    end
    if (flush) issue_valid_d = 1'b0;
  end

  // Control state: valid bits, age matrix and issue slot.
  // NOTE: sequential state is updated only with non-blocking assignments (<=), so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      older_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
    end else begin
      valid_q       <= valid_d;
      older_q       <= older_d;
      issue_valid_q <= issue_valid_d;
      issue_q       <= issue_d;
    end
  end

  // Entry payload storage.
  // NOTE: the payload array has no reset. Its contents are ignored while the matching valid bit is clear.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  // Count of valid entries. The issue slot is not included.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < RS_DEPTH; i++) occupancy = occupancy + OCC_W'(valid_q[i]);
  end

  assign issue_valid      = issue_valid_q;
  assign issue_is_store   = issue_q.is_store;
  assign issue_funct3     = issue_q.funct3;
  assign issue_tag        = issue_q.tag;
  assign issue_base       = issue_q.base;
  assign issue_imm        = issue_q.imm;
  assign issue_store_data = issue_q.store_data;

endmodule

// File: tb/tb_lsu_age_rs.sv
// tb_lsu_age_rs: directed and randomized bench for lsu_age_rs.
// The reference model is a queue of ops kept in dispatch (age) order, plus one
// issue-slot record. It is updated once per clock edge.
module tb_lsu_age_rs;
  localparam int RS_DEPTH  = 8;
  localparam int ROB_DEPTH = 16;
  localparam int NUM_CDB   = 4;
  localparam int XLEN      = 32;
  localparam int TAG_W     = $clog2(ROB_DEPTH);
  localparam int OCC_W     = $clog2(RS_DEPTH) + 1;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b1;
  logic                          flush = 1'b0;
  logic                          disp_valid = 1'b0;
  logic                          disp_ready;
  logic                          disp_is_store = 1'b0;
  logic [2:0]                    disp_funct3 = '0;
  logic [TAG_W-1:0]              disp_tag_dest = '0;
  logic [TAG_W-1:0]              disp_tag_a = '0;
  logic [XLEN-1:0]               disp_data_a = '0;
  logic                          disp_rdy_a = 1'b0;
  logic [TAG_W-1:0]              disp_tag_b = '0;
  logic [XLEN-1:0]               disp_data_b = '0;
  logic                          disp_rdy_b = 1'b0;
  logic [XLEN-1:0]               disp_imm = '0;
  logic [NUM_CDB-1:0]            cdb_valid = '0;
  logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag = '0;
  logic [NUM_CDB-1:0][XLEN-1:0]  cdb_data = '0;
  logic                          commit_valid = 1'b0;
  logic [TAG_W-1:0]              commit_tag = '0;
  logic [XLEN-1:0]               commit_data = '0;
  logic                          issue_valid;
  logic                          issue_ready = 1'b1;
  logic                          issue_is_store;
  logic [2:0]                    issue_funct3;
  logic [TAG_W-1:0]              issue_tag;
  logic [XLEN-1:0]               issue_base;
  logic [XLEN-1:0]               issue_imm;
  logic [XLEN-1:0]               issue_store_data;
  logic [OCC_W-1:0]              occupancy;

  lsu_age_rs #(.RS_DEPTH(RS_DEPTH), .ROB_DEPTH(ROB_DEPTH), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_store(disp_is_store),
    .disp_funct3(disp_funct3), .disp_tag_dest(disp_tag_dest),
    .disp_tag_a(disp_tag_a), .disp_data_a(disp_data_a), .disp_rdy_a(disp_rdy_a),
    .disp_tag_b(disp_tag_b), .disp_data_b(disp_data_b), .disp_rdy_b(disp_rdy_b),
    .disp_imm(disp_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_data(commit_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_is_store(issue_is_store),
    .issue_funct3(issue_funct3), .issue_tag(issue_tag), .issue_base(issue_base),
    .issue_imm(issue_imm), .issue_store_data(issue_store_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit             is_store;
    bit [2:0]       f3;
    bit [TAG_W-1:0] tag;
    bit [TAG_W-1:0] tag_a;
    bit [TAG_W-1:0] tag_b;
    bit [XLEN-1:0]  a;
    bit [XLEN-1:0]  b;
    bit [XLEN-1:0]  imm;
    bit             ra;
    bit             rb;
  } op_t;

  op_t rs[$];   // ops in age order, oldest first
  op_t slot;
  bit  slot_v = 1'b0;

  // Search the result buses for a tag: the lowest CDB channel wins, then the commit port.
  function automatic bit lookup(input bit [TAG_W-1:0] t, output bit [XLEN-1:0] d);
    for (int c = 0; c < NUM_CDB; c++) begin
      if (cdb_valid[c] && cdb_tag[c] == t) begin
        d = cdb_data[c];
        return 1'b1;
      end
    end
    if (commit_valid && commit_tag == t) begin
      d = commit_data;
      return 1'b1;
    end
    d = '0;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit            full;
    bit            fire;
    int            pick;
    bit [XLEN-1:0] d;
    op_t           o;
`ifdef LSU_RS_STORE_ORDER_EN
    bit            older_store;
    older_store = 1'b0;
`endif
    full = rs.size() >= RS_DEPTH;
    fire = !slot_v || issue_ready;
    pick = -1;
    for (int k = 0; k < rs.size(); k++) begin
      bit ok;
      ok = rs[k].ra && (rs[k].rb || !rs[k].is_store);
`ifdef LSU_RS_STORE_ORDER_EN
      if (!rs[k].is_store && (older_store || (slot_v && slot.is_store && !issue_ready))) ok = 1'b0;
      if (rs[k].is_store) older_store = 1'b1;
`endif
      if (ok) begin
        pick = k;
        break;
      end
    end
    if (fire) begin
      if (pick >= 0) begin
        slot   = rs[pick];
        slot_v = 1'b1;
        rs.delete(pick);
      end else begin
        slot_v = 1'b0;
      end
    end
    for (int k = 0; k < rs.size(); k++) begin
      o = rs[k];
      if (!o.ra && lookup(o.tag_a, d)) begin o.a = d; o.ra = 1'b1; end
      if (!o.rb && lookup(o.tag_b, d)) begin o.b = d; o.rb = 1'b1; end
      rs[k] = o;
    end
    if (disp_valid && !full) begin
      o.is_store = disp_is_store;
      o.f3       = disp_funct3;
      o.tag      = disp_tag_dest;
      o.tag_a    = disp_tag_a;
      o.tag_b    = disp_tag_b;
      o.imm      = disp_imm;
      o.a        = disp_data_a;
      o.ra       = disp_rdy_a;
      if (!disp_rdy_a && lookup(disp_tag_a, d)) begin o.a = d; o.ra = 1'b1; end
      o.b        = disp_data_b;
      o.rb       = disp_rdy_b || !disp_is_store;
      if (!o.rb && lookup(disp_tag_b, d)) begin o.b = d; o.rb = 1'b1; end
      rs.push_back(o);
    end
    if (flush) begin
      rs.delete();
      slot_v = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("issue_valid", 64'(issue_valid), 64'(slot_v));
    check("disp_ready", 64'(disp_ready), 64'(rs.size() < RS_DEPTH));
    check("occupancy", 64'(occupancy), 64'(rs.size()));
    if (slot_v) begin
      check("issue_tag", 64'(issue_tag), 64'(slot.tag));
      check("issue_is_store", 64'(issue_is_store), 64'(slot.is_store));
      check("issue_funct3", 64'(issue_funct3), 64'(slot.f3));
      check("issue_base", 64'(issue_base), 64'(slot.a));
      check("issue_imm", 64'(issue_imm), 64'(slot.imm));
      if (slot.is_store) check("issue_store_data", 64'(issue_store_data), 64'(slot.b));
    end
  endtask

  // One clock: the model advances at the edge, and the outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_idle();
    disp_valid   = 1'b0;
    flush        = 1'b0;
    cdb_valid    = '0;
    commit_valid = 1'b0;
  endtask

  task automatic drive_disp(input bit st, input bit [2:0] f3, input bit [TAG_W-1:0] tag,
                            input bit [TAG_W-1:0] ta, input bit ra, input bit [XLEN-1:0] a,
                            input bit [TAG_W-1:0] tb, input bit rb, input bit [XLEN-1:0] b,
                            input bit [XLEN-1:0] imm);
    disp_valid    = 1'b1;
    disp_is_store = st;
    disp_funct3   = f3;
    disp_tag_dest = tag;
    disp_tag_a    = ta;
    disp_rdy_a    = ra;
    disp_data_a   = a;
    disp_tag_b    = tb;
    disp_rdy_b    = rb;
    disp_data_b   = b;
    disp_imm      = imm;
  endtask

  initial begin
    // ---- reset ----
    #2 rst_n = 1'b0;
    #1;
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_disp_ready", 64'(disp_ready), 64'd1);
    check("rst_issue_tag", 64'(issue_tag), 64'd0);
    check("rst_issue_base", 64'(issue_base), 64'd0);
    check("rst_issue_imm", 64'(issue_imm), 64'd0);
    check("rst_issue_store_data", 64'(issue_store_data), 64'd0);
    check("rst_issue_is_store", 64'(issue_is_store), 64'd0);
    check("rst_issue_funct3", 64'(issue_funct3), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ---- single ready load: visible two cycles after dispatch ----
    issue_ready = 1'b1;
    drive_disp(1'b0, 3'b010, 4'd3, 4'd0, 1'b1, 32'h1000, 4'd0, 1'b0, 32'h0, 32'h10);
    cycle();
    set_idle();
    check("t1_not_yet_valid", 64'(issue_valid), 64'd0);
    check("t1_occ_one", 64'(occupancy), 64'd1);
    cycle();
    check("t1_valid", 64'(issue_valid), 64'd1);
    check("t1_base", 64'(issue_base), 64'h1000);
    check("t1_imm", 64'(issue_imm), 64'h10);
    check("t1_tag", 64'(issue_tag), 64'd3);
    check("t1_occ_zero", 64'(occupancy), 64'd0);
    cycle();

    // ---- store whose data arrives on CDB channel 2 ----
    drive_disp(1'b1, 3'b010, 4'd5, 4'd0, 1'b1, 32'h2000, 4'd7, 1'b0, 32'h0, 32'h4);
    cycle();
    set_idle();
    cdb_valid[2] = 1'b1;
    cdb_tag[2]   = 4'd7;
    cdb_data[2]  = 32'hDEAD;
    cycle();
    set_idle();
    cycle();
    check("t2_valid", 64'(issue_valid), 64'd1);
    check("t2_tag", 64'(issue_tag), 64'd5);
    check("t2_store_data", 64'(issue_store_data), 64'hDEAD);
    cycle();

    // ---- fill all entries, then wake them youngest-first in one cycle ----
    for (int k = 0; k < RS_DEPTH; k++) begin
      drive_disp(1'b0, 3'b000, TAG_W'(k), TAG_W'(8 + (7 - k) / 2), 1'b0, 32'h0,
                 4'd0, 1'b0, 32'h0, 32'(k * 4));
      cycle();
    end
    set_idle();
    check("t3_full_not_ready", 64'(disp_ready), 64'd0);
    check("t3_occ_full", 64'(occupancy), 64'd8);
    drive_disp(1'b0, 3'b000, 4'd9, 4'd0, 1'b1, 32'h0, 4'd0, 1'b0, 32'h0, 32'h0);
    cycle();
    set_idle();
    cdb_valid = '1;
    for (int c = 0; c < NUM_CDB; c++) begin
      cdb_tag[c]  = TAG_W'(8 + c);
      cdb_data[c] = 32'hA0 + 32'(c);
    end
    cycle();
    set_idle();
    for (int k = 0; k < RS_DEPTH; k++) begin
      cycle();
      check("t3_issue_order", 64'(issue_tag), 64'(k));
    end
    cycle();

    // ---- back-pressure: payload held for 5 cycles ----
    issue_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive_disp(1'b0, 3'b001, TAG_W'(k), 4'd0, 1'b1, 32'(k * 'h100), 4'd0, 1'b0, 32'h0, 32'(k));
      cycle();
    end
    set_idle();
    for (int n = 0; n < 5; n++) begin
      cycle();
      check("t4_hold_valid", 64'(issue_valid), 64'd1);
      check("t4_hold_tag", 64'(issue_tag), 64'd1);
      check("t4_hold_base", 64'(issue_base), 64'h100);
      check("t4_hold_occ", 64'(occupancy), 64'd2);
    end
    issue_ready = 1'b1;
    cycle();
    check("t4_next_tag", 64'(issue_tag), 64'd2);
    cycle();
    check("t4_last_tag", 64'(issue_tag), 64'd3);
    cycle();

    // ---- flush with a stalled slot, four entries and a dispatch in the same cycle ----
    issue_ready = 1'b0;
    drive_disp(1'b0, 3'b000, 4'd1, 4'd0, 1'b1, 32'h11, 4'd0, 1'b0, 32'h0, 32'h0);
    cycle();
    for (int k = 2; k <= 5; k++) begin
      drive_disp(1'b0, 3'b000, TAG_W'(k), 4'd15, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 32'h0);
      cycle();
    end
    set_idle();
    check("t5_pre_occ", 64'(occupancy), 64'd4);
    check("t5_pre_valid", 64'(issue_valid), 64'd1);
    flush = 1'b1;
    drive_disp(1'b0, 3'b000, 4'd6, 4'd0, 1'b1, 32'h66, 4'd0, 1'b0, 32'h0, 32'h0);
    cycle();
    set_idle();
    check("t5_valid", 64'(issue_valid), 64'd0);
    check("t5_occ", 64'(occupancy), 64'd0);
    check("t5_disp_ready", 64'(disp_ready), 64'd1);
    issue_ready = 1'b1;
    cycle();
    check("t5_dropped", 64'(issue_valid), 64'd0);

    // ---- older unready store followed by a ready load ----
    drive_disp(1'b1, 3'b010, 4'd4, 4'd0, 1'b1, 32'h3000, 4'd12, 1'b0, 32'h0, 32'h8);
    cycle();
    drive_disp(1'b0, 3'b010, 4'd6, 4'd0, 1'b1, 32'h4000, 4'd0, 1'b0, 32'h0, 32'hC);
    cycle();
    set_idle();
    cycle();
`ifdef LSU_RS_STORE_ORDER_EN
    check("t6_load_blocked", 64'(issue_valid), 64'd0);
`else
    check("t6_load_first", 64'(issue_valid), 64'd1);
    check("t6_load_tag", 64'(issue_tag), 64'd6);
`endif
    commit_valid = 1'b1;
    commit_tag   = 4'd12;
    commit_data  = 32'hBEEF;
    cycle();
    set_idle();
    repeat (4) cycle();

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 2000; n++) begin
      disp_valid    = ($urandom_range(0, 99) < 60);
      disp_is_store = $urandom_range(0, 1) == 1;
      disp_funct3   = 3'($urandom_range(0, 7));
      disp_tag_dest = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
      disp_tag_a    = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
      disp_tag_b    = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
      disp_rdy_a    = $urandom_range(0, 1) == 1;
      disp_rdy_b    = $urandom_range(0, 1) == 1;
      disp_data_a   = $urandom();
      disp_data_b   = $urandom();
      disp_imm      = $urandom();
      for (int c = 0; c < NUM_CDB; c++) begin
        cdb_valid[c] = ($urandom_range(0, 99) < 40);
        cdb_tag[c]   = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
        cdb_data[c]  = $urandom();
      end
      commit_valid = ($urandom_range(0, 99) < 30);
      commit_tag   = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
      commit_data  = $urandom();
      issue_ready  = ($urandom_range(0, 99) < 75);
      flush        = ($urandom_range(0, 49) == 0);
      cycle();
    end
    set_idle();
    issue_ready = 1'b1;
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
